// File: rtl/cube_pkg.sv
// Shared types, corner slot numbering and cycle/twist helpers for the cube-state engines.
package cube_pkg;

  typedef enum logic [2:0] {
    FACE_U = 3'd0,
    FACE_D = 3'd1,
    FACE_F = 3'd2,
    FACE_B = 3'd3,
    FACE_R = 3'd4,
    FACE_L = 3'd5
  } face_e;

  typedef enum logic [1:0] {
    DIR_CW   = 2'd0,
    DIR_CCW  = 2'd1,
    DIR_HALF = 2'd2
  } dir_e;

  localparam logic [2:0] SLOT_UFL = 3'd0;
  localparam logic [2:0] SLOT_UFR = 3'd1;
  localparam logic [2:0] SLOT_UBR = 3'd2;
  localparam logic [2:0] SLOT_UBL = 3'd3;
  localparam logic [2:0] SLOT_DFL = 3'd4;
  localparam logic [2:0] SLOT_DFR = 3'd5;
  localparam logic [2:0] SLOT_DBR = 3'd6;
  localparam logic [2:0] SLOT_DBL = 3'd7;

  // Slot visited at position idx of the clockwise cycle of a face; rows packed {p3,p2,p1,p0}.
  function automatic logic [2:0] face_cycle(input logic [2:0] face, input logic [1:0] idx);
    logic [11:0] row;
    case (face)
      FACE_U:  row = {SLOT_UFR, SLOT_UBR, SLOT_UBL, SLOT_UFL};
      FACE_D:  row = {SLOT_DBL, SLOT_DBR, SLOT_DFR, SLOT_DFL};
      FACE_F:  row = {SLOT_DFL, SLOT_DFR, SLOT_UFR, SLOT_UFL};
      FACE_B:  row = {SLOT_DBR, SLOT_DBL, SLOT_UBL, SLOT_UBR};
      FACE_R:  row = {SLOT_DFR, SLOT_DBR, SLOT_UBR, SLOT_UFR};
      FACE_L:  row = {SLOT_DBL, SLOT_DFL, SLOT_UFL, SLOT_UBL};
      default: row = '0;
    endcase
    return row[3*idx +: 3];
  endfunction

  function automatic logic [1:0] twist_add(input logic [1:0] ori, input logic [1:0] amt);
    logic [2:0] sum;
    sum = (ori == 2'd3) ? {1'b0, amt} : ({1'b0, ori} + {1'b0, amt});
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/corner_move_engine_if.sv
// Command handshake plus cube-state memory bus of the corner move engine.
interface corner_move_engine_if #(
  parameter int AW = 24,
  parameter int DW = 24
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_face;
  logic [1:0]    cmd_dir;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  cmd_valid, cmd_face, cmd_dir, mem_rdata,
    output cmd_ready, mem_addr, mem_we, mem_wdata, busy, done, err
  );

  modport slave (
    output cmd_valid, cmd_face, cmd_dir, mem_rdata,
    input  cmd_ready, mem_addr, mem_we, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/corner_permute.sv
// Combinational corner permutation: word k of the result is the new content of cycle position k.
module corner_permute
  import cube_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic [3:0][DW-1:0] in_w,
  input  logic [2:0]         face,
  input  logic [1:0]         dir,
  output logic [3:0][DW-1:0] out_w
);
  logic twisted;

  // Only quarter turns of the side faces change corner orientation.
  assign twisted = (dir != DIR_HALF) && (face != FACE_U) && (face != FACE_D);

  for (genvar gi = 0; gi < 4; gi++) begin : g_pos
    localparam int SRC_CW   = (gi + 3) % 4;
    localparam int SRC_CCW  = (gi + 1) % 4;
    localparam int SRC_HALF = (gi + 2) % 4;
    localparam logic [1:0] AMT = (gi % 2 == 1) ? 2'd1 : 2'd2;
    logic [DW-1:0] src;

    always_comb begin
      case (dir)
        DIR_CW:  src = in_w[SRC_CW];
        DIR_CCW: src = in_w[SRC_CCW];
        default: src = in_w[SRC_HALF];
      endcase
    end

    assign out_w[gi] = {src[DW-1:2], twist_add(src[1:0], twisted ? AMT : 2'd0)};
  end
endmodule

// File: rtl/corner_move_engine.sv
// Executes one face turn per command: reads four corner words, writes back the permuted and twisted set.
module corner_move_engine
  import cube_pkg::*;
#(
  parameter int            AW        = 24,
  parameter int            DW        = 24,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input logic                  clk,
  input logic                  rst,
  corner_move_engine_if.master bus
);
  typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, WR0, WR1, WR2, WR3, FIN} state_e;

  state_e            state_q, state_d;
  logic [2:0]        face_q, face_d;
  logic [1:0]        dir_q, dir_d;
  logic [3:0][DW-1:0] buf_q, buf_d, perm_w;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              we_q, we_d, ready_q, ready_d, busy_q, busy_d;
  logic              done_q, done_d, err_q, err_d;
  logic              illegal;
  logic [1:0]        slot_k;

  always_comb begin
    state_d = state_q;
    face_d  = face_q;
    dir_d   = dir_q;
    buf_d   = buf_q;
    illegal = (bus.cmd_face > 3'd5) || (bus.cmd_dir == 2'd3);
    case (state_q)
      IDLE: if (bus.cmd_valid && ready_q) begin
        face_d  = bus.cmd_face;
        dir_d   = bus.cmd_dir;
        state_d = illegal ? FIN : RD0;
      end
      RD0: begin buf_d[0] = bus.mem_rdata; state_d = RD1; end
      RD1: begin buf_d[1] = bus.mem_rdata; state_d = RD2; end
      RD2: begin buf_d[2] = bus.mem_rdata; state_d = RD3; end
      RD3: begin buf_d[3] = bus.mem_rdata; state_d = WR0; end
      WR0: state_d = WR1;
      WR1: state_d = WR2;
      WR2: state_d = WR3;
      WR3: state_d = FIN;
      default: state_d = IDLE;
    endcase
  end

  // Permute from the next-cycle buffers so WR0's word already sees the RD3 capture.
  corner_permute #(.DW(DW)) u_permute (
    .in_w  (buf_d),
    .face  (face_d),
    .dir   (dir_d),
    .out_w (perm_w)
  );

  // Outputs are decoded from the next state so every bus signal comes straight from a flop.
  always_comb begin
    case (state_d)
      RD1, WR1: slot_k = 2'd1;
      RD2, WR2: slot_k = 2'd2;
      RD3, WR3: slot_k = 2'd3;
      default:  slot_k = 2'd0;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == FIN);
    err_d   = (state_d == FIN) && (state_q == IDLE);
    busy_d  = (state_d != IDLE) && (state_d != FIN);
    we_d    = state_d inside {WR0, WR1, WR2, WR3};
    addr_d  = busy_d ? BASE_ADDR + AW'(face_cycle(face_d, slot_k)) : BASE_ADDR;
    wdata_d = we_d ? perm_w[slot_k] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      face_q  <= '0;
      dir_q   <= '0;
      buf_q   <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      face_q  <= face_d;
      dir_q   <= dir_d;
      buf_q   <= buf_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_corner_move_engine.sv
// Bench for corner_move_engine: spec vectors, timing corner cases and random turns against a cube model.
module tb_corner_move_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  corner_move_engine_if #(.AW(24), .DW(24)) bus ();

  corner_move_engine #(.AW(24), .DW(24), .BASE_ADDR(24'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int bad_addr = 0;
  logic [23:0] mem [8];
  logic [23:0] model_m [8];
  int cyc [6][4];

  assign bus.mem_rdata = (bus.mem_addr < 24'd8) ? mem[bus.mem_addr[2:0]] : 24'hDEAD00;

  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_count = wr_count + 1;
      if (bus.mem_addr < 24'd8) mem[bus.mem_addr[2:0]] = bus.mem_wdata;
      else bad_addr = bad_addr + 1;
    end
  end

  typedef struct {
    logic [2:0] face;
    logic [1:0] dir;
    int         exp_done;
    bit         exp_err;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Cube model: every piece moves one step along its face cycle and gains the landing twist.
  function automatic void model_move(input logic [2:0] f, input logic [1:0] d);
    logic [23:0] old [8];
    int dst, tw, o, n;
    if (f > 3'd5 || d == 2'd3) return;
    old = model_m;
    for (int k = 0; k < 4; k++) begin
      case (d)
        2'd0:    dst = (k + 1) % 4;
        2'd1:    dst = (k + 3) % 4;
        default: dst = (k + 2) % 4;
      endcase
      tw = 0;
      if (d != 2'd2 && f >= 3'd2) tw = (dst % 2 == 1) ? 1 : 2;
      o = (old[cyc[f][k]][1:0] == 2'd3) ? 0 : int'(old[cyc[f][k]][1:0]);
      n = (o + tw) % 3;
      model_m[cyc[f][dst]] = {old[cyc[f][k]][23:2], n[1:0]};
    end
  endfunction

  task automatic load_identity();
    for (int i = 0; i < 8; i++) begin
      mem[i] = 24'(i) << 2;
      model_m[i] = mem[i];
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) begin
      mem[i] = {22'($urandom_range(0, 4194303)), 2'($urandom_range(0, 2))};
      model_m[i] = mem[i];
    end
  endtask

  task automatic check_mem(input string nm);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_slot%0d", nm, i), mem[i], model_m[i]);
  endtask

  task automatic chk_identity(input string nm);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_id%0d", nm, i), mem[i], 24'(i) << 2);
  endtask

  task automatic wait_ready(input string nm);
    int guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_ready_wait"}, bus.cmd_ready, 1);
  endtask

  // Issues one command at a negedge, tracks it cycle by cycle and checks timing and memory.
  task automatic run_cmd(input logic [2:0] f, input logic [1:0] d, input int exp_done,
                         input bit exp_err, input string nm);
    int dc, w0;
    bit er, rdy_bad, busy_bad, legal;
    legal = (f <= 3'd5) && (d != 2'd3);
    wait_ready(nm);
    w0 = wr_count;
    bus.cmd_valid = 1'b1;
    bus.cmd_face  = f;
    bus.cmd_dir   = d;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_face  = 3'($urandom);
    bus.cmd_dir   = 2'($urandom);
    dc = -1; er = 0; rdy_bad = 0; busy_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      if (dc < 0 && bus.done === 1'b1) begin
        dc = c;
        er = bus.err;
      end
      if (dc < 0 || c == dc) begin
        if (bus.cmd_ready !== 1'b0) rdy_bad = 1;
        if (bus.busy !== (legal && c <= 8)) busy_bad = 1;
      end else begin
        chk({nm, "_ready_back"}, bus.cmd_ready, 1);
        break;
      end
      @(negedge clk);
    end
    model_move(f, d);
    $display("cmd %s face=%0d dir=%0d done_cycle=%0d err=%0d writes=%0d",
             nm, f, d, dc, er, wr_count - w0);
    chk({nm, "_done_cycle"}, dc, exp_done);
    chk({nm, "_err"}, er, exp_err);
    chk({nm, "_ready_low"}, rdy_bad, 0);
    chk({nm, "_busy"}, busy_bad, 0);
    chk({nm, "_writes"}, wr_count - w0, legal ? 4 : 0);
    check_mem(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int dc, hs2, w0, rf, rd;
    cyc = '{'{0, 3, 2, 1}, '{4, 5, 6, 7}, '{0, 1, 5, 4},
            '{2, 3, 7, 6}, '{1, 2, 6, 5}, '{3, 0, 4, 7}};
    vecs[0] = '{3'd0, 2'd0, 9, 1'b0};
    vecs[1] = '{3'd1, 2'd1, 9, 1'b0};
    vecs[2] = '{3'd2, 2'd2, 9, 1'b0};
    vecs[3] = '{3'd3, 2'd0, 9, 1'b0};
    vecs[4] = '{3'd4, 2'd1, 9, 1'b0};
    vecs[5] = '{3'd5, 2'd0, 9, 1'b0};
    vecs[6] = '{3'd6, 2'd0, 1, 1'b1};
    vecs[7] = '{3'd7, 2'd1, 1, 1'b1};
    vecs[8] = '{3'd2, 2'd3, 1, 1'b1};
    vecs[9] = '{3'd5, 2'd2, 9, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_face  = '0;
    bus.cmd_dir   = '0;
    load_identity();

    #2;
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_addr", bus.mem_addr, 0);
    chk("idle_we", bus.mem_we, 0);

    // Spec test-plan sequences with literal expected words.
    run_cmd(3'd0, 2'd0, 9, 1'b0, "u_cw");
    chk("u_cw_s3", mem[3], 24'd0);
    chk("u_cw_s2", mem[2], 24'd12);
    chk("u_cw_s1", mem[1], 24'd8);
    chk("u_cw_s0", mem[0], 24'd4);

    load_identity();
    run_cmd(3'd2, 2'd0, 9, 1'b0, "f_cw");
    chk("f_cw_s1", mem[1], 24'd1);
    chk("f_cw_s5", mem[5], 24'd6);
    chk("f_cw_s4", mem[4], 24'd21);
    chk("f_cw_s0", mem[0], 24'd18);
    run_cmd(3'd2, 2'd1, 9, 1'b0, "f_ccw");
    chk_identity("f_undo");

    run_cmd(3'd4, 2'd2, 9, 1'b0, "r_half");
    chk("r_half_s1", mem[1], 24'd24);
    chk("r_half_s6", mem[6], 24'd4);
    chk("r_half_s2", mem[2], 24'd20);
    chk("r_half_s5", mem[5], 24'd8);
    run_cmd(3'd4, 2'd2, 9, 1'b0, "r_half2");
    chk_identity("r_undo");

    run_cmd(3'd6, 2'd0, 1, 1'b1, "ill_face");
    run_cmd(3'd0, 2'd3, 1, 1'b1, "ill_dir");

    // Table vectors, applied in sequence from the identity cube.
    load_identity();
    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].face, vecs[i].dir, vecs[i].exp_done, vecs[i].exp_err, $sformatf("vec%0d", i));

    // cmd_valid held across two commands.
    load_identity();
    wait_ready("b2b");
    w0 = wr_count;
    bus.cmd_valid = 1'b1;
    bus.cmd_face  = 3'd0;
    bus.cmd_dir   = 2'd0;
    @(posedge clk);
    hs2 = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        hs2 = c;
        break;
      end
    end
    chk("b2b_second_hs_cycle", hs2, 10);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    dc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (bus.done === 1'b1) begin
        dc = c;
        break;
      end
      @(negedge clk);
    end
    model_move(3'd0, 2'd0);
    model_move(3'd0, 2'd0);
    $display("cmd b2b second_hs=%0d second_done=%0d writes=%0d", hs2, dc, wr_count - w0);
    chk("b2b_second_done", dc, 9);
    chk("b2b_writes", wr_count - w0, 8);
    check_mem("b2b");

    // Reset asserted while WR1 is on the bus.
    load_identity();
    wait_ready("rstwr");
    w0 = wr_count;
    bus.cmd_valid = 1'b1;
    bus.cmd_face  = 3'd0;
    bus.cmd_dir   = 2'd0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstwr_we_before", bus.mem_we, 1);
    chk("rstwr_writes_before", wr_count - w0, 1);
    #1 rst = 1'b1;
    #1;
    $display("cmd rstwr reset_mid_write we=%0d ready=%0d", bus.mem_we, bus.cmd_ready);
    chk("rstwr_we", bus.mem_we, 0);
    chk("rstwr_addr", bus.mem_addr, 0);
    chk("rstwr_wdata", bus.mem_wdata, 0);
    chk("rstwr_busy", bus.busy, 0);
    chk("rstwr_done", bus.done, 0);
    chk("rstwr_err", bus.err, 0);
    chk("rstwr_ready", bus.cmd_ready, 0);
    w0 = wr_count;
    repeat (3) @(negedge clk);
    chk("rstwr_no_writes", wr_count - w0, 0);
    rst = 1'b0;
    @(negedge clk);
    wait_ready("rstwr_after");
    load_identity();
    run_cmd(3'd0, 2'd0, 9, 1'b0, "rstwr_ucw");
    chk("rstwr_ucw_s0", mem[0], 24'd4);
    chk("rstwr_ucw_s3", mem[3], 24'd0);

    // Random turns from random cubes.
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) load_random();
      rf = $urandom_range(0, 5);
      rd = $urandom_range(0, 2);
      if ($urandom_range(0, 11) == 0) rf = $urandom_range(6, 7);
      if ($urandom_range(0, 11) == 0) rd = 3;
      run_cmd(3'(rf), 2'(rd), (rf > 5 || rd == 3) ? 1 : 9, (rf > 5 || rd == 3),
              $sformatf("rnd%0d", i));
    end

    chk("no_out_of_range_writes", bad_addr, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/corner_move_engine.md
Name: corner_move_engine

Overview:
- Upstream command stage of the 24-bit cube-state memory. Owns that memory's addr/we/in bus and reads its out port.
- Executes one face turn per command on the 8 corner entries stored at BASE_ADDR..BASE_ADDR+7.
- Per turn: read 4 corner words, permute them, add orientation twist, write all 4 back.
- Sits between the solver/move sequencer (command side) and the cube-state memory (memory side).

Parameters:
- BASE_ADDR, 0, memory address of corner slot 0. Slots 0..7 are at BASE_ADDR+0..+7.
- AW, 24, memory address width.
- DW, 24, memory data width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  move command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_face  in  3  face code: 0 U, 1 D, 2 F, 3 B, 4 R, 5 L. Codes 6 and 7 are illegal.
- cmd_dir  in  2  turn direction: 0 clockwise, 1 counter-clockwise, 2 half turn. Code 3 is illegal.
- mem_addr  out  AW  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; combinational from mem_addr.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  one-cycle pulse with done when the command was illegal.

Behaviour:
- Corner slots: 0 UFL, 1 UFR, 2 UBR, 3 UBL, 4 DFL, 5 DFR, 6 DBR, 7 DBL.
- Word format: bits [1:0] = orientation (0..2); bits [DW-1:2] = piece id, passed through unchanged.
- Clockwise cycle (p0,p1,p2,p3): content of p0 moves to p1, p1 to p2, p2 to p3, p3 to p0.
  - U (0,3,2,1)
  - D (4,5,6,7)
  - F (0,1,5,4)
  - B (2,3,7,6)
  - R (1,2,6,5)
  - L (3,0,4,7)
- Counter-clockwise: reverse cycle, i.e. p1 to p0, p2 to p1, p3 to p2, p0 to p3.
- Half turn: swap p0 and p2, swap p1 and p3; no twist.
- Twist, quarter turns on F/B/R/L only: a word landing at p1 or p3 gets +1 mod 3; a word landing at p0 or p2 gets +2 mod 3. U/D quarter turns apply no twist. An input orientation of 3 is treated as 0 before the add.
- FSM states: IDLE, RD0-RD3, WR0-WR3, FIN.
  - IDLE: cmd_ready=1, busy=0. A handshake (cmd_valid & cmd_ready) latches face and dir and moves to RD0. An illegal command moves straight to FIN with err set.
  - RDk: mem_addr = BASE_ADDR + pk, mem_we=0. mem_rdata is captured into buffer k at the cycle's clock edge.
  - WRk: mem_addr = BASE_ADDR + pk, mem_we=1, mem_wdata = permuted and twisted word for slot pk. Buffered data is used, so reads are never affected by this command's own writes.
  - FIN: done=1 (err=1 if illegal), busy=0, cmd_ready=0; then IDLE.
- Timing, handshake at edge 0:
  - Legal command: RD0 in cycle 1, WR3 in cycle 8, done in cycle 9, cmd_ready high again in cycle 10.
  - Illegal command: done+err in cycle 1; no memory access.
- busy=1 in the RD and WR states only. cmd_ready=0 whenever not in IDLE. cmd_face/cmd_dir are ignored outside the handshake.
- In IDLE, mem_addr holds BASE_ADDR, mem_we=0, mem_wdata=0.
- Reset (asynchronous, active-high):
  - Outputs: state IDLE, cmd_ready=0 while rst is high, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, buffers=0.
  - Reset mid-write leaves memory partially permuted; the sequencer must reload the cube state.
  - The memory's own reset is synchronous and active-low; the top level drives it from the inverse of rst.
- Back-to-back commands: the second is accepted in cycle 10 at the earliest. No queuing.

Decomposition:
- Shared package cube_pkg:
  - face and dir enums.
  - corner slot constants.
  - 6x4 cycle table as a constant function face_cycle(face, idx).
  - function twist_add(ori, amt).
- One sub-module, corner_permute: combinational. Inputs: 4 buffered words, face, dir. Output: 4 write words. The FSM and bus control stay in corner_move_engine.

Test Plan:
- Memory preloaded with slot i = {i,2'b00}; command U cw -> writes slot3={0,0}, slot2={3,0}, slot1={2,0}, slot0={1,0}; done in cycle 9; slots 4-7 untouched.
- Identity cube, F cw -> slot1={0,1}, slot5={1,2}, slot4={5,1}, slot0={4,2}; then F ccw restores all orientations to 0.
- Identity cube, R half -> slot1↔slot6 and slot2↔slot5 swapped, all orientations 0; applying R half again restores identity.
- Command face=6, then dir=3 -> done+err in cycle 1, mem_we never asserted, cmd_ready back in cycle 2.
- cmd_valid held high for two commands -> second handshake no earlier than cycle 10; cmd_ready=0 in cycles 1-9.
- rst asserted during WR1 -> mem_we drops without waiting for a clock edge, all outputs reach reset values, no further writes; after release, cmd_ready=1 and a new U cw completes normally.
